// File: rtl/bcd_pkg.sv
// Shared BCD helpers: digit limits, nibble clamp, constant predecessor,
// and the per-edge action encoding used by the up/down timer.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // What the timer does on the coming edge, in priority order.
  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_LOAD = 2'd1,
    ACT_STEP = 2'd2,
    ACT_WRAP = 2'd3
  } act_e;

  // Any nibble above 9 is forced to 9 so the register only ever holds legal BCD.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

  // BCD value minus one, up to eight digits. Used at elaboration to find the
  // count that sits one step below a preset.
  function automatic logic [31:0] bcd_pred(input logic [31:0] val);
    logic [31:0] res;
    logic        borrow;
    res    = val;
    borrow = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (borrow) begin
        if (val[4*i +: 4] == BCD_ZERO) begin
          res[4*i +: 4] = BCD_MAX;
        end else begin
          res[4*i +: 4] = val[4*i +: 4] - 4'd1;
          borrow        = 1'b0;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_updown_timer_if.sv
// Control and status bundle of the BCD up/down timer.
// master drives the controls, slave is the timer itself.
interface bcd_updown_timer_if #(
  parameter int DIGITS = 2
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   cnt;
  logic                  tc;
  logic                  done;

  modport master (
    output en, up, load, load_val,
    input  cnt, tc, done
  );

  modport slave (
    input  en, up, load, load_val,
    output cnt, tc, done
  );
endinterface

// File: rtl/bcd_digit.sv
// One decade of the timer: a 0..9 register that loads, increments or
// decrements with 9<->0 rollover, and flags when it sits at 0 or 9.
import bcd_pkg::*;

module bcd_digit (
  input  logic       clk,
  input  logic       rst_n,       // active-high asynchronous reset
  input  logic [3:0] i_rst_val,
  input  logic       i_step,
  input  logic       i_up,
  input  logic       i_load,
  input  logic [3:0] i_load_nib,
  output logic [3:0] o_digit,
  output logic       o_at_min,
  output logic       o_at_max
);

  logic [3:0] r_digit;

  // Decade register: load beats step; rollover keeps the digit in 0..9.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_digit <= i_rst_val;
    end else if (i_load) begin
      r_digit <= bcd_clamp(i_load_nib);
    end else if (i_step) begin
      if (i_up) begin
        r_digit <= (r_digit >= BCD_MAX) ? BCD_ZERO : r_digit + 4'd1;
      end else begin
        r_digit <= (r_digit == BCD_ZERO) ? BCD_MAX : r_digit - 4'd1;
      end
    end
  end

  assign o_digit  = r_digit;
  assign o_at_min = (r_digit == BCD_ZERO);
  assign o_at_max = (r_digit == BCD_MAX);

endmodule

// File: rtl/bcd_updown_timer.sv
// Parametrised BCD up/down timer. Counts DIGITS decimal digits between 0 and
// PRESET, with load, enable, hold-or-wrap at terminal count, a terminal-count
// level and a registered one-cycle done pulse.
import bcd_pkg::*;

module bcd_updown_timer #(
  parameter int                  DIGITS = 2,
  parameter logic [4*DIGITS-1:0] PRESET = 8'h30,
  parameter bit                  WRAP   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,   // active-high asynchronous reset
  bcd_updown_timer_if.slave bus
);

  localparam int                  W           = 4 * DIGITS;
  localparam logic [31:0]         PRESET_32   = 32'(PRESET);
  localparam logic [31:0]         PRED_32     = bcd_pred(PRESET_32);
  // An up step from this value lands exactly on PRESET.
  localparam logic [W-1:0]        PRESET_PRED = PRED_32[W-1:0];
  // A down step from this value lands exactly on zero.
  localparam logic [W-1:0]        CNT_ONE     = W'(1);

  act_e             w_act;
  logic [W-1:0]     w_cnt;
  logic [W-1:0]     w_load_val;
  logic             w_load;
  logic [DIGITS-1:0] w_step;
  logic [DIGITS-1:0] w_at_min;
  logic [DIGITS-1:0] w_at_max;
  logic             w_tc;
  logic             w_lands;
  logic             r_done;

  // Terminal count. All-nines is terminal for any legal preset, so it short-
  // circuits the magnitude compare; all-zeros is the down terminal.
  assign w_tc = bus.up ? ((&w_at_max) || (w_cnt >= PRESET)) : (&w_at_min);

  // Per-edge action: load > enable (step, or wrap/hold at terminal) > hold.
  always_comb begin
    w_act = ACT_HOLD;
    if (bus.load) begin
      w_act = ACT_LOAD;
    end else if (bus.en) begin
      if (!w_tc) begin
        w_act = ACT_STEP;
      end else if (WRAP) begin
        w_act = ACT_WRAP;
      end
    end
  end

  // Wrap reuses the digit load path with the opposite end of the range.
  always_comb begin
    w_load_val = bus.load_val;
    if (w_act == ACT_WRAP) begin
      w_load_val = bus.up ? '0 : PRESET;
    end
  end

  assign w_load = (w_act == ACT_LOAD) || (w_act == ACT_WRAP);

  // Ripple enables: a digit moves only when every lower digit is about to roll.
  always_comb begin
    w_step    = '0;
    w_step[0] = (w_act == ACT_STEP);
    for (int i = 1; i < DIGITS; i++) begin
      w_step[i] = w_step[i-1] & (bus.up ? w_at_max[i-1] : w_at_min[i-1]);
    end
  end

  // A step lands on terminal when it starts one below it in the step direction.
  assign w_lands = bus.up ? (w_cnt == PRESET_PRED) : (w_cnt == CNT_ONE);

  // done pulses on the edge a counting step reaches terminal; never on load/wrap.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (w_act == ACT_STEP) && w_lands;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_rst_val  (PRESET[4*g +: 4]),
      .i_step     (w_step[g]),
      .i_up       (bus.up),
      .i_load     (w_load),
      .i_load_nib (w_load_val[4*g +: 4]),
      .o_digit    (w_cnt[4*g +: 4]),
      .o_at_min   (w_at_min[g]),
      .o_at_max   (w_at_max[g])
    );
  end

  assign bus.cnt  = w_cnt;
  assign bus.tc   = w_tc;
  assign bus.done = r_done;

endmodule

// File: doc/bcd_updown_timer.md
# bcd_updown_timer

Parametrised BCD up/down timer, successor to the fixed two-digit 30-to-0 down counter. It counts DIGITS decimal digits in either direction between 0 and a preset limit, with runtime load, count enable, selectable hold-or-wrap at the terminal count, a terminal-count level and a one-cycle done pulse. It drives seven-segment display logic and sequencing FSMs in the lab designs.

## Interface
- DIGITS, 2: number of BCD digits; 1..8.
- PRESET, 8'h30: BCD limit, width 4*DIGITS; every nibble must be 0..9.
- WRAP, 0: 0 = hold at terminal count; 1 = wrap at terminal count.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-high reset (asserted = 1).
- en  in  1  count enable; one step per clk while high.
- up  in  1  direction: 1 = count up, 0 = count down.
- load  in  1  synchronous load of load_val.
- load_val  in  4*DIGITS  BCD value to load.
- cnt  out  4*DIGITS  current BCD count, registered.
- tc  out  1  terminal-count level, combinational from cnt and up.
- done  out  1  one-cycle pulse, registered.

## Operation
- Terminal value: 0 when up=0; PRESET when up=1. tc = (up ? cnt >= PRESET : cnt == 0). The compare is a plain unsigned compare, which is valid for legal BCD.
- Priority per edge: reset > load > en > hold.
- Load:
  - Each load_val nibble greater than 9 is clamped to 9 before it is stored.
  - done is not asserted on a load, even if the loaded value is terminal.
- Count step (en=1, load=0, tc=0):
  - Down: digit 0 decrements. Digit i decrements only when digits 0..i-1 are all 0. A decrementing 0 becomes 9.
  - Up: digit 0 increments. Digit i increments only when digits 0..i-1 are all 9. An incrementing 9 becomes 0.
  - Carry and borrow never leave the top digit, because tc stops the count first.
- At terminal (en=1, load=0, tc=1):
  - WRAP=0: cnt holds. done stays low.
  - WRAP=1: cnt becomes PRESET when counting down and 0 when counting up. done stays low on this wrap step.
- done=1 for exactly one cycle when a count step lands cnt on the terminal value for the current direction.
- Changing up mid-count takes effect on the next edge, with no extra latency.
- Up mode when cnt > PRESET (only possible after a load): tc=1, so the block holds (WRAP=0) or wraps to 0 (WRAP=1).

## Timing
- Reset values: cnt = PRESET, done = 0. tc then follows from cnt and up.
- Reset is asynchronous. Asserting it mid-count forces the reset values immediately. The first step after release occurs on the first rising edge with en=1.
- Load latency: cnt = clamped load_val one edge after load is sampled high.
- Count latency: one edge per step. done asserts on the same edge that cnt reaches the terminal value and deasserts on the next edge.
- Down from PRESET=30 with en held high: 30 steps to 00. done is high in the cycle cnt shows 00.
- Simultaneous load and en: load wins and no step occurs.
- en=0: cnt and the internal state are frozen; done=0.

## Structure
- Shared package bcd_pkg: BCD_MAX = 4'd9, BCD_ZERO = 4'd0, and a clamp function (nibble > 9 maps to 9). Other BCD display blocks reuse it.
- Sub-module bcd_digit: one decade register.
  - Inputs: clk, rst_n, rst value, step, up, load, load nibble.
  - Outputs: digit, at_min (digit == 0), at_max (digit == 9).
  - The top level chains the at_min/at_max signals into ripple enables for the higher digits, and holds the tc, wrap and done logic.

## Test plan
- Reset, DIGITS=2, PRESET=8'h30, up=0, en=1 -> cnt sequence 30, 29, 28 … 10, 09 … 00. done is high only in the cycle cnt=00. cnt then holds 00 with tc=1.
- WRAP=1, down, cnt=01 -> cnt 00 with done=1, then 30 with done=0, then 29.
- up=1, load 8'h28 -> cnt 28, 29, 30. done=1 at 30, then cnt holds 30. Repeat with WRAP=1: 30 -> 00.
- DIGITS=3, PRESET=12'h999, up=1: load 12'h099, one step -> 100. Load 12'h100, up=0, one step -> 099.
- load_val 8'hAF -> cnt 99 and done=0. load and en high together -> cnt equals the load value.
- Assert rst_n mid-count for a sub-cycle width -> cnt returns to 30 before the next edge and done=0. Toggling up mid-count -> direction reverses on the following edge.
